// File: rtl/tx_interp_fir.sv
// Polyphase x8 interpolating FIR for the DAC path: 5 Msps in, 40 Msps out on clk.
// Two time-shared 16x12 multipliers, one output slot every two clocks.
module tx_interp_fir (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] indata,
  output logic               in_req,
  output logic signed [11:0] outdata,
  output logic               out_stb
);

  logic        [3:0]  cnt;
  logic signed [15:0] x0, x1, x2, x3;
  logic signed [27:0] prod_a, prod_b;
  logic signed [29:0] acc;
  logic               started;

  logic        [2:0]  phase;
  logic        [4:0]  idx_a, idx_b;
  logic signed [15:0] xa, xb;
  logic signed [11:0] ca, cb;
  logic signed [29:0] sum_ab;
  logic signed [29:0] acc_sh;
  logic signed [11:0] sat_val;

  // Prototype lowpass is symmetric, so only h[0..15] is stored; index k>=16 folds to 31-k.
  function automatic logic signed [11:0] coef(input logic [4:0] idx);
    logic [3:0] k;
    k = idx[4] ? ~idx[3:0] : idx[3:0];
    case (k)
      4'd0:  coef = -12'sd40;
      4'd1:  coef = -12'sd60;
      4'd2:  coef = -12'sd70;
      4'd3:  coef = -12'sd60;
      4'd4:  coef = -12'sd20;
      4'd5:  coef = 12'sd50;
      4'd6:  coef = 12'sd150;
      4'd7:  coef = 12'sd280;
      4'd8:  coef = 12'sd430;
      4'd9:  coef = 12'sd590;
      4'd10: coef = 12'sd750;
      4'd11: coef = 12'sd890;
      4'd12: coef = 12'sd1000;
      4'd13: coef = 12'sd1080;
      4'd14: coef = 12'sd1130;
      default: coef = 12'sd1150;
    endcase
  endfunction

  // cnt[3:1] is the output phase; cnt[0] picks taps {0,1} or {2,3}.
  always_comb begin
    phase  = cnt[3:1];
    idx_a  = {cnt[0], 1'b0, phase};
    idx_b  = {cnt[0], 1'b1, phase};
    xa     = cnt[0] ? x2 : x0;
    xb     = cnt[0] ? x3 : x1;
    ca     = coef(idx_a);
    cb     = coef(idx_b);
    sum_ab = {{2{prod_a[27]}}, prod_a} + {{2{prod_b[27]}}, prod_b};
    acc_sh = acc >>> 11;
    if (acc_sh > 30'sd2047)
      sat_val = 12'sd2047;
    else if (acc_sh < -30'sd2048)
      sat_val = -12'sd2048;
    else
      sat_val = acc_sh[11:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      in_req  <= 1'b0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      x3      <= '0;
      prod_a  <= '0;
      prod_b  <= '0;
      acc     <= '0;
      outdata <= '0;
      out_stb <= 1'b0;
      started <= 1'b0;
    end else begin
      cnt    <= cnt + 4'd1;
      in_req <= (cnt == 4'd14);
      if (cnt == 4'd15) begin
        x0 <= indata;
        x1 <= x0;
        x2 <= x1;
        x3 <= x2;
      end
      prod_a <= $signed({{12{xa[15]}}, xa}) * $signed({{16{ca[11]}}, ca});
      prod_b <= $signed({{12{xb[15]}}, xb}) * $signed({{16{cb[11]}}, cb});
      // Odd cnt closes a slot: publish the finished sum and restart the accumulator.
      if (cnt[0]) begin
        acc     <= sum_ab;
        outdata <= sat_val;
        out_stb <= 1'b0;
      end else begin
        acc     <= acc + sum_ab;
        out_stb <= started;
      end
      if (cnt == 4'd3)
        started <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_interp_fir.sv
// Directed/table-driven bench for tx_interp_fir: a queue of expected outputs is
// consumed on every out_stb pulse; expectations come from hand tables or a polyphase model.
module tb_tx_interp_fir;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] indata = '0;
  logic               in_req;
  logic signed [11:0] outdata;
  logic               out_stb;

  tx_interp_fir dut (
    .clk     (clk),
    .rst     (rst),
    .indata  (indata),
    .in_req  (in_req),
    .outdata (outdata),
    .out_stb (out_stb)
  );

  always #6 clk = ~clk;

  typedef struct packed {
    logic signed [15:0] din;
    logic               hand;
    logic [7:0][11:0]   exp;
  } vec_t;

  vec_t tbl[40];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;
  int   expq[$];
  int   xh[4];
  int   h[32];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int din, input bit hand, input int e0, input int e1, input int e2,
                     input int e3, input int e4, input int e5, input int e6, input int e7);
    vec_t v;
    v.din    = 16'(din);
    v.hand   = hand;
    v.exp[0] = 12'(e0); v.exp[1] = 12'(e1); v.exp[2] = 12'(e2); v.exp[3] = 12'(e3);
    v.exp[4] = 12'(e4); v.exp[5] = 12'(e5); v.exp[6] = 12'(e6); v.exp[7] = 12'(e7);
    tbl[nv] = v;
    nv++;
  endtask

  function automatic int model(input int p);
    longint s;
    s = longint'(h[p]) * xh[0] + longint'(h[p+8]) * xh[1] +
        longint'(h[p+16]) * xh[2] + longint'(h[p+24]) * xh[3];
    s = s >>> 11;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return int'(s);
  endfunction

  // Every out_stb pulse reports the value written one cycle earlier.
  always @(negedge clk) begin
    if (!rst && out_stb === 1'b1 && expq.size() > 0)
      check("outdata", outdata, expq.pop_front());
  end

  task automatic feed(input logic signed [15:0] din);
    int n;
    n = 0;
    @(negedge clk);
    while (in_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL in_req_timeout: got %0d expected 1", in_req);
    end
    indata = din;
    @(posedge clk);
    #1;
    indata = 16'($urandom);
    check("in_req_fall", in_req, 0);
    xh[3] = xh[2];
    xh[2] = xh[1];
    xh[1] = xh[0];
    xh[0] = int'(din);
  endtask

  task automatic release_and_check();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) xh[i] = 0;
    expq.delete();
    for (int i = 0; i < 8; i++) expq.push_back(0);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 4)  check("out_stb_edge4", out_stb, 0);
      if (k == 5)  check("out_stb_edge5", out_stb, 1);
      if (k == 14) check("in_req_cyc14", in_req, 0);
      if (k == 15) check("in_req_cyc15", in_req, 1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    feed(v.din);
    for (int p = 0; p < 8; p++) begin
      if (v.hand) expq.push_back(int'($signed(v.exp[p])));
      else        expq.push_back(model(p));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
  endtask

  initial begin
    int hh[16];
    logic signed [15:0] r;
    hh = '{-40, -60, -70, -60, -20, 50, 150, 280, 430, 590, 750, 890, 1000, 1080, 1130, 1150};
    for (int k = 0; k < 16; k++) begin
      h[k]      = hh[k];
      h[31 - k] = hh[k];
    end

    // impulse 2048 -> h[0..31] then 0
    add( 2048, 1,  -40,  -60,  -70,  -60,  -20,   50,  150,  280);
    add(    0, 1,  430,  590,  750,  890, 1000, 1080, 1130, 1150);
    add(    0, 1, 1150, 1130, 1080, 1000,  890,  750,  590,  430);
    add(    0, 1,  280,  150,   50,  -20,  -60,  -70,  -60,  -40);
    add(    0, 1,    0,    0,    0,    0,    0,    0,    0,    0);
    // negative impulse
    add(-2048, 1,   40,   60,   70,   60,   20,  -50, -150, -280);
    add(    0, 1, -430, -590, -750, -890,-1000,-1080,-1130,-1150);
    add(    0, 1,-1150,-1130,-1080,-1000, -890, -750, -590, -430);
    add(    0, 1, -280, -150,  -50,   20,   60,   70,   60,   40);
    add(    0, 1,    0,    0,    0,    0,    0,    0,    0,    0);
    // DC 2048: steady state is the per-phase coefficient sum
    add( 2048, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 2048, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 2048, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 2048, 1, 1820, 1810, 1810, 1810, 1810, 1810, 1810, 1820);
    add( 2048, 1, 1820, 1810, 1810, 1810, 1810, 1810, 1810, 1820);
    // saturation, then recovery from -32768 back to 0
    add( 32767, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 32767, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 32767, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 32767, 1, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
    add(-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(-32768, 1, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
    add(     0, 1, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
    add(     0, 1, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
    add(     0, 1, -2048, -2048, -800, 320, 960, 1120, 960, 640);
    add(     0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_outdata", outdata, 0);
    check("rst_in_req", in_req, 0);
    check("rst_out_stb", out_stb, 0);
    release_and_check();

    for (int i = 0; i < nv; i++) run_vec(tbl[i]);

    // random stream with junk on indata outside the in_req cycle
    for (int i = 0; i < 1000; i++) begin
      r = 16'($urandom);
      feed(r);
      for (int p = 0; p < 8; p++) expq.push_back(model(p));
    end
    drain();

    // asynchronous reset mid-slot with nonzero data in flight
    feed(16'sd12000);
    for (int p = 0; p < 8; p++) expq.push_back(model(p));
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    expq.delete();
    #1;
    check("midrst_outdata", outdata, 0);
    check("midrst_in_req", in_req, 0);
    check("midrst_out_stb", out_stb, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_outdata", outdata, 0);
      check("hold_out_stb", out_stb, 0);
    end
    release_and_check();
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
